// File: rtl/uart_tx_frame_pkg.sv
// Shared definitions for the UART transmit path (and the matching receiver).
// Contents: FSM state encodings (3-bit) and the data-bit count of one frame.
package uart_tx_frame_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

endpackage

// File: rtl/uart_tx_frame_baud_tick.sv
// uart_baud_tick: bit-period counter.
// Counts 0..CLKS_PER_BIT-1 and wraps. tick is high in the last cycle of a bit
// period. clr forces the count back to 0, so a new bit starts on the next cycle.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   clr    in  restart the bit period
//   tick   out last cycle of the current bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter draining NUM_BYTES bytes from a FIFO per start.
// Each byte is fetched over a read/rd-done handshake and sent as an 8N1 frame
// (optional even parity), LSB first.
// Ports:
//   clk_tx_i        in   clock
//   reset           in   synchronous active-high reset
//   start           in   request to send NUM_BYTES bytes (ignored unless idle)
//   fifo_read_o     out  FIFO read request, high while fetching
//   fifo_rd_done_i  in   FIFO read complete, fifo_data_i valid
//   fifo_data_i     in   byte from FIFO
//   tx_o            out  serial line, idle high
//   busy_o          out  high from accepted start until frame_done_o
//   frame_done_o    out  one-cycle pulse after the last stop bit
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_BYTES    = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk_tx_i,
  input  logic       reset,
  input  logic       start,
  output logic       fifo_read_o,
  input  logic       fifo_rd_done_i,
  input  logic [7:0] fifo_data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       frame_done_o
);

  localparam int BCW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic [2:0]     state, state_nxt;
  logic [7:0]     shreg, shreg_nxt;
  logic [2:0]     bit_cnt, bit_cnt_nxt;
  logic [BCW-1:0] byte_cnt, byte_cnt_nxt;
  logic           par_bit, par_nxt;
  logic           tx_nxt;
  logic           tick;

  // Restarting the bit period on every state change keeps each bit exactly
  // CLKS_PER_BIT cycles, regardless of how long FETCH waited.
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk_tx_i),
    .reset (reset),
    .clr   (state_nxt != state),
    .tick  (tick)
  );

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    par_nxt      = par_bit;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: if (fifo_rd_done_i) begin
        shreg_nxt   = fifo_data_i;
        par_nxt     = ^fifo_data_i;
        bit_cnt_nxt = '0;
        state_nxt   = ST_START;
      end
      ST_START: if (tick) state_nxt = ST_DATA;
      ST_DATA:  if (tick) begin
        if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
          state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end else begin
          shreg_nxt   = shreg >> 1;
          bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      ST_PARITY: if (tick) state_nxt = ST_STOP;
      ST_STOP:  if (tick) begin
        if (byte_cnt == BCW'(NUM_BYTES - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          byte_cnt_nxt = byte_cnt + 1'b1;
          state_nxt    = ST_FETCH;
        end
      end
      ST_DONE: begin
        byte_cnt_nxt = '0;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // tx_o is registered from the next-state view so the line changes in the
    // same cycle the state does (start bit begins right after capture).
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shreg_nxt[0];
      ST_PARITY: tx_nxt = par_nxt;
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_tx_i) begin
    if (reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      par_bit  <= 1'b0;
      tx_o     <= 1'b1;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      par_bit  <= par_nxt;
      tx_o     <= tx_nxt;
    end
  end

  assign fifo_read_o  = (state == ST_FETCH);
  assign busy_o       = (state != ST_IDLE);
  assign frame_done_o = (state == ST_DONE);

endmodule
